// File: rtl/data_mem_dp_if.sv
// rtl/data_mem_dp_if.sv - load/store request and read-response bundle for data_mem_dp
interface data_mem_dp_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic         ClearReq;
  logic         WriteEn;
  logic [A-1:0] WrAddr;
  logic [W-1:0] DataIn;
  logic         ReadEn;
  logic [A-1:0] RdAddr;
  logic [W-1:0] DataOut;
  logic         RdValid;
  logic         Busy;

  modport master (
    output ClearReq, WriteEn, WrAddr, DataIn, ReadEn, RdAddr,
    input  DataOut, RdValid, Busy
  );

  modport slave (
    input  ClearReq, WriteEn, WrAddr, DataIn, ReadEn, RdAddr,
    output DataOut, RdValid, Busy
  );
endinterface

// File: rtl/data_mem_dp.sv
// rtl/data_mem_dp.sv - dual-address data memory with registered read, write bypass and sweep clear
module data_mem_dp #(
  parameter int W          = 8,
  parameter int A          = 8,
  parameter int CLR_ON_RST = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  data_mem_dp_if.slave  bus
);
  localparam int       DEPTH    = 1 << A;
  localparam bit       CLR_INIT = (CLR_ON_RST != 0);

  typedef enum logic {CLEAR, IDLE} state_t;
  localparam state_t RST_STATE = CLR_INIT ? CLEAR : IDLE;
  localparam logic [A-1:0] LAST_ADDR = {A{1'b1}};

  logic [W-1:0] core_mem [DEPTH];

  state_t       state_q, state_d;
  logic [A-1:0] clr_ptr_q, clr_ptr_d;
  logic [W-1:0] dout_q, dout_d;
  logic         rd_valid_q, rd_valid_d;
  logic         busy_q, busy_d;

  logic         mem_we;
  logic [A-1:0] mem_waddr;
  logic [W-1:0] mem_wdata;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    busy_d     = busy_q;
    mem_we     = 1'b0;
    mem_waddr  = bus.WrAddr;
    mem_wdata  = bus.DataIn;
    case (state_q)
      CLEAR: begin
        // All requests are ignored while sweeping; only the clear write reaches the array.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      IDLE: begin
        if (bus.ClearReq) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end else begin
          mem_we = bus.WriteEn;
          if (bus.ReadEn) begin
            rd_valid_d = 1'b1;
            dout_d     = (bus.WriteEn && (bus.WrAddr == bus.RdAddr)) ? bus.DataIn
                                                                      : core_mem[bus.RdAddr];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= RST_STATE;
      clr_ptr_q  <= '0;
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= CLR_INIT;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
    end
  end

  // The array has no reset; clearing it is the job of the sweep.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      core_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.RdValid = rd_valid_q;
  assign bus.Busy    = busy_q;
endmodule
